// File: rtl/delay_scan_generator.sv
// delay_scan_generator
// Raster-scans an image frame and, for every pixel, computes one receive-delay
// index per array channel. A single digit-by-digit square-root unit is shared
// by all channels (one result bit per cycle). Each finished pixel bundle is
// presented on a valid/ready handshake and held stable until it is accepted.
module delay_scan_generator #(
  parameter int          PIXEL_COLUMN = 320,
  parameter int          PIXEL_ROW    = 240,
  parameter int          N_SIDE       = 4,
  parameter int          PITCH        = 80,
  parameter int          R2_W         = 20,
  parameter int unsigned FOCAL_SQ     = 0,
  parameter int          SHIFT        = 0,
  parameter int unsigned DELTA_OFFSET = 0,
  parameter int          DELTA_W      = 8,
  localparam int         NCH          = N_SIDE * N_SIDE,
  localparam int         PXW          = $clog2(PIXEL_COLUMN),
  localparam int         PYW          = $clog2(PIXEL_ROW)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic signed [PXW-1:0]    o_px,
  output logic signed [PYW-1:0]    o_py,
  output logic [NCH*DELTA_W-1:0]   o_delta,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int SQ_W     = R2_W / 2;
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int COL_W    = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;
  // Largest element offset from the array centre, in pixels.
  localparam int OFF_MAX  = PITCH * (N_SIDE - 1) / 2;
  localparam int OFW      = $clog2(OFF_MAX + 1) + 1;
  localparam int PMAX_W   = (PXW > PYW) ? PXW : PYW;
  // One spare bit so pixel + offset can never overflow, and PITCH*col fits.
  localparam int RX_W     = ((PMAX_W > OFW) ? PMAX_W : OFW) + 1;
  localparam int R2A_W    = (2 * RX_W + 1 > 32) ? 2 * RX_W + 1 : 32;
  localparam int R2S_W    = ((R2A_W > R2_W) ? R2A_W : R2_W) + 1;
  localparam int DS_W     = ((SQ_W > 32) ? SQ_W : 32) + 1;

  localparam logic signed [PXW-1:0]  PX_MIN   = PXW'(-(PIXEL_COLUMN / 2));
  localparam logic signed [PXW-1:0]  PX_MAX   = PXW'(PIXEL_COLUMN / 2 - 1);
  localparam logic signed [PYW-1:0]  PY_MIN   = PYW'(-(PIXEL_ROW / 2));
  localparam logic signed [PYW-1:0]  PY_MAX   = PYW'(PIXEL_ROW / 2 - 1);
  localparam logic [CH_W-1:0]        CH_LAST  = CH_W'(NCH - 1);
  localparam logic [COL_W-1:0]       COL_LAST = COL_W'(N_SIDE - 1);
  localparam logic [R2_W-1:0]        BIT_INIT = {2'b01, {(R2_W - 2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SQRT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_n;
  logic signed [PXW-1:0]    r_px;
  logic signed [PYW-1:0]    r_py;
  logic [CH_W-1:0]          r_ch;
  logic [COL_W-1:0]         r_col;
  logic [COL_W-1:0]         r_row;
  logic [R2_W-1:0]          r_rem;
  logic [R2_W-1:0]          r_res;
  logic [R2_W-1:0]          r_bit;
  logic [NCH*DELTA_W-1:0]   r_stage;

  logic signed [RX_W-1:0]   w_off_x;
  logic signed [RX_W-1:0]   w_off_y;
  logic signed [RX_W-1:0]   w_rx;
  logic signed [RX_W-1:0]   w_ry;
  logic [RX_W-1:0]          w_rx_abs;
  logic [RX_W-1:0]          w_ry_abs;
  logic [2*RX_W-1:0]        w_rx_sq;
  logic [2*RX_W-1:0]        w_ry_sq;
  logic [R2S_W-1:0]         w_r2_full;
  logic [R2_W-1:0]          w_r2_sat;
  logic [R2_W-1:0]          w_trial;
  logic [R2_W-1:0]          w_rem_n;
  logic [R2_W-1:0]          w_res_n;
  logic [SQ_W-1:0]          w_root;
  logic [DS_W-1:0]          w_sum;
  logic [DELTA_W-1:0]       w_delta;
  logic                     w_last_pix;
  logic                     w_abort;

  assign w_last_pix = (r_px == PX_MAX) && (r_py == PY_MAX);
  assign w_abort    = i_abort && (r_state != S_IDLE);

  // Channel geometry and saturated radius-squared for the current channel.
  always_comb begin
    w_off_x   = RX_W'(OFF_MAX) - RX_W'(PITCH * int'(r_col));
    w_off_y   = RX_W'(OFF_MAX) - RX_W'(PITCH * int'(r_row));
    w_rx      = RX_W'(r_px) + w_off_x;
    w_ry      = RX_W'(r_py) + w_off_y;
    w_rx_abs  = w_rx[RX_W-1] ? RX_W'(-w_rx) : RX_W'(w_rx);
    w_ry_abs  = w_ry[RX_W-1] ? RX_W'(-w_ry) : RX_W'(w_ry);
    w_rx_sq   = (2*RX_W)'(w_rx_abs) * (2*RX_W)'(w_rx_abs);
    w_ry_sq   = (2*RX_W)'(w_ry_abs) * (2*RX_W)'(w_ry_abs);
    w_r2_full = R2S_W'(w_rx_sq) + R2S_W'(w_ry_sq) + R2S_W'(FOCAL_SQ);
    if (w_r2_full > R2S_W'({R2_W{1'b1}})) begin
      w_r2_sat = {R2_W{1'b1}};
    end else begin
      w_r2_sat = w_r2_full[R2_W-1:0];
    end
  end

  // One digit-by-digit square-root step, then shift/offset/clamp of the root.
  always_comb begin
    w_trial = r_res + r_bit;
    if (r_rem >= w_trial) begin
      w_rem_n = r_rem - w_trial;
      w_res_n = (r_res >> 1) + r_bit;
    end else begin
      w_rem_n = r_rem;
      w_res_n = r_res >> 1;
    end
    w_root = w_res_n[SQ_W-1:0];
    w_sum  = DS_W'(w_root >> SHIFT) + DS_W'(DELTA_OFFSET);
    if (w_sum > DS_W'({DELTA_W{1'b1}})) begin
      w_delta = {DELTA_W{1'b1}};
    end else begin
      w_delta = w_sum[DELTA_W-1:0];
    end
  end

  // FSM next state; abort from any busy state wins over everything else.
  always_comb begin
    w_state_n = r_state;
    if (w_abort) begin
      w_state_n = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_n = i_start ? S_LOAD : S_IDLE;
        S_LOAD: w_state_n = S_SQRT;
        S_SQRT: begin
          if (r_bit[0]) begin
            w_state_n = (r_ch == CH_LAST) ? S_OUT : S_LOAD;
          end else begin
            w_state_n = S_SQRT;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            w_state_n = w_last_pix ? S_DONE : S_LOAD;
          end else begin
            w_state_n = S_OUT;
          end
        end
        S_DONE:  w_state_n = S_IDLE;
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Scan counters, square-root registers and the staging bundle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_px    <= '0;
      r_py    <= '0;
      r_ch    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_rem   <= '0;
      r_res   <= '0;
      r_bit   <= '0;
      r_stage <= '0;
    end else if (w_abort) begin
      r_stage <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_px  <= PX_MIN;
            r_py  <= PY_MIN;
            r_ch  <= '0;
            r_col <= '0;
            r_row <= '0;
          end
        end
        S_LOAD: begin
          r_rem <= w_r2_sat;
          r_res <= '0;
          r_bit <= BIT_INIT;
        end
        S_SQRT: begin
          r_rem <= w_rem_n;
          r_res <= w_res_n;
          r_bit <= r_bit >> 2;
          if (r_bit[0]) begin
            for (int c = 0; c < NCH; c++) begin
              if (r_ch == CH_W'(c)) begin
                r_stage[c*DELTA_W +: DELTA_W] <= w_delta;
              end
            end
            if (r_ch != CH_LAST) begin
              r_ch <= r_ch + CH_W'(1);
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + COL_W'(1);
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end
        end
        S_OUT: begin
          if (i_ready && !w_last_pix) begin
            if (r_px == PX_MAX) begin
              r_px <= PX_MIN;
              r_py <= r_py + PYW'(1);
            end else begin
              r_px <= r_px + PXW'(1);
            end
            r_ch  <= '0;
            r_col <= '0;
            r_row <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_valid = (r_state == S_OUT);
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign o_px    = r_px;
  assign o_py    = r_py;
  assign o_delta = r_stage;

endmodule

// File: tb/tb_delay_scan_generator.sv
// Testbench for delay_scan_generator: a 4x2 frame instance exercises the scan,
// handshake, abort and reset behaviour; three 2x2 instances cover shift/offset
// clamping and radius saturation. Expected bundles come from a plain-arithmetic
// reference model of the delay formula.
module tb_delay_scan_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_start, a_abort, a_ready;
  logic p_start, p_abort, p_ready;

  logic              a_valid, a_busy, a_done;
  logic signed [1:0] a_px;
  logic signed [0:0] a_py;
  logic [127:0]      a_delta;

  logic              b_valid, b_busy, b_done, c_valid, c_busy, c_done, d_valid, d_busy, d_done;
  logic signed [0:0] b_px, b_py, c_px, c_py, d_px, d_py;
  logic [127:0]      b_delta, c_delta, d_delta;

  int checks   = 0;
  int failures = 0;

  delay_scan_generator #(.PIXEL_COLUMN(4), .PIXEL_ROW(2)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_abort(a_abort), .i_ready(a_ready),
    .o_valid(a_valid), .o_px(a_px), .o_py(a_py), .o_delta(a_delta), .o_busy(a_busy), .o_done(a_done));

  delay_scan_generator #(.PIXEL_COLUMN(2), .PIXEL_ROW(2), .SHIFT(2), .DELTA_OFFSET(140)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(p_start), .i_abort(p_abort), .i_ready(p_ready),
    .o_valid(b_valid), .o_px(b_px), .o_py(b_py), .o_delta(b_delta), .o_busy(b_busy), .o_done(b_done));

  delay_scan_generator #(.PIXEL_COLUMN(2), .PIXEL_ROW(2), .SHIFT(2), .DELTA_OFFSET(250)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_start(p_start), .i_abort(p_abort), .i_ready(p_ready),
    .o_valid(c_valid), .o_px(c_px), .o_py(c_py), .o_delta(c_delta), .o_busy(c_busy), .o_done(c_done));

  delay_scan_generator #(.PIXEL_COLUMN(2), .PIXEL_ROW(2), .FOCAL_SQ(1048576)) u_dut_d (
    .i_clk(clk), .i_rst(rst), .i_start(p_start), .i_abort(p_abort), .i_ready(p_ready),
    .o_valid(d_valid), .o_px(d_px), .o_py(d_py), .o_delta(d_delta), .o_busy(d_busy), .o_done(d_done));

  // Floor square root by direct search.
  function automatic longint isqrt_ref(longint v);
    longint s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  // Expected 16-channel bundle for a 4x4 array with pitch 80 and R2_W=20.
  function automatic logic [127:0] ref_bundle(int px, int py, longint focal, int shift, int offset);
    logic [127:0] b = '0;
    for (int c = 0; c < 16; c++) begin
      longint rx = longint'(px) + (80 * (3 - 2 * (c % 4))) / 2;
      longint ry = longint'(py) + (80 * (3 - 2 * (c / 4))) / 2;
      longint r2 = rx * rx + ry * ry + focal;
      longint d;
      if (r2 > 64'd1048575) r2 = 64'd1048575;
      d = (isqrt_ref(r2) >>> shift) + offset;
      if (d > 255) d = 255;
      b[c*8 +: 8] = 8'(d);
    end
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b0;
    p_start = 1'b0; p_abort = 1'b0; p_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_valid, a_busy, a_done} !== 3'b000) begin
      failures++; $display("FAIL reset_flags actual=%b required=000", {a_valid, a_busy, a_done});
    end
    checks++;
    if (a_px !== 2'b00 || a_py !== 1'b0 || a_delta !== 128'd0) begin
      failures++; $display("FAIL reset_data actual=%0d,%0d,%h required=0,0,0", a_px, a_py, a_delta);
    end
    checks++;
    if ({b_valid, b_busy, d_valid, d_busy} !== 4'b0000 || b_delta !== 128'd0) begin
      failures++; $display("FAIL reset_others actual=%b required=0000", {b_valid, b_busy, d_valid, d_busy});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset actual=%b required=0", a_busy);
    end
  endtask

  task automatic test_full_frame();
    int n = 0, low = 0, cyc = 0, done_cnt = 0, done_at = -1, last_hs = -1;
    int ex, ey;
    logic [127:0] eb;
    a_ready = 1'b1;
    a_start = 1'b1;
    while (cyc < 2000 && (n < 8 || cyc < last_hs + 5)) begin
      @(negedge clk);
      a_start = 1'b0;
      cyc++;
      if (a_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
        a_start = 1'b1;  // must be ignored: FSM is still in DONE
      end
      if (a_valid) begin
        ex = -2 + n % 4; ey = -1 + n / 4;
        eb = ref_bundle(ex, ey, 0, 0, 0);
        checks++;
        if (low != 176) begin
          failures++; $display("FAIL frame_gap bundle=%0d actual=%0d required=176", n, low);
        end
        checks++;
        if (a_px !== 2'(ex) || a_py !== 1'(ey) || a_delta !== eb) begin
          failures++; $display("FAIL frame_bundle n=%0d actual=(%0d,%0d) %h required=(%0d,%0d) %h", n, a_px, a_py, a_delta, ex, ey, eb);
        end
        if (n == 6) begin
          checks++;
          if (a_delta[7:0] !== 8'd169 || a_delta[47:40] !== 8'd56 || a_delta[127:120] !== 8'd169 || a_delta[55:48] !== 8'd56) begin
            failures++; $display("FAIL centre_channels actual=%0d,%0d,%0d,%0d required=169,56,169,56", a_delta[7:0], a_delta[47:40], a_delta[127:120], a_delta[55:48]);
          end
        end
        n++; low = 0; last_hs = cyc;
      end else begin
        low++;
      end
    end
    a_start = 1'b0;
    checks++;
    if (n != 8) begin
      failures++; $display("FAIL frame_count actual=%0d required=8", n);
    end
    checks++;
    if (done_cnt != 1 || done_at != last_hs + 1) begin
      failures++; $display("FAIL frame_done actual=%0d pulses at %0d required=1 pulse at %0d", done_cnt, done_at, last_hs + 1);
    end
    checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
      failures++; $display("FAIL frame_idle actual=%b%b required=00", a_busy, a_valid);
    end
  endtask

  task automatic test_backpressure();
    int n = 0, low = 0, cyc = 0, done_cnt = 0, last_hs = -1, wait_left = -1;
    int ex, ey;
    logic [127:0] eb;
    a_ready = 1'b0;
    a_start = 1'b1;
    while (cyc < 6000 && (n < 8 || cyc < last_hs + 5)) begin
      @(negedge clk);
      a_start = 1'b0;
      cyc++;
      if (a_done) done_cnt++;
      if (n < 8 && last_hs >= 0 && cyc == last_hs + 1) begin
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b1) begin
          failures++; $display("FAIL after_handshake actual=%b%b required=01", a_valid, a_busy);
        end
      end
      if (a_valid) begin
        ex = -2 + n % 4; ey = -1 + n / 4;
        eb = ref_bundle(ex, ey, 0, 0, 0);
        if (wait_left < 0) begin
          checks++;
          if (low != 176) begin
            failures++; $display("FAIL bp_gap bundle=%0d actual=%0d required=176", n, low);
          end
          wait_left = (n == 1) ? 50 : $urandom_range(0, 4);
        end
        checks++;
        if (a_px !== 2'(ex) || a_py !== 1'(ey) || a_delta !== eb) begin
          failures++; $display("FAIL bp_stable n=%0d actual=(%0d,%0d) %h required=(%0d,%0d) %h", n, a_px, a_py, a_delta, ex, ey, eb);
        end
        if (wait_left == 0) begin
          a_ready = 1'b1; n++; last_hs = cyc; wait_left = -1; low = 0;
        end else begin
          a_ready = 1'b0; wait_left--;
        end
      end else begin
        a_ready = 1'($urandom_range(0, 1));
        low++;
      end
    end
    a_ready = 1'b0;
    checks++;
    if (n != 8 || done_cnt != 1 || a_busy !== 1'b0) begin
      failures++; $display("FAIL bp_frame actual=%0d bundles %0d done busy=%b required=8 bundles 1 done busy=0", n, done_cnt, a_busy);
    end
  endtask

  task automatic test_abort();
    int n = 0, cyc = 0, rs, j, bad = 0;
    a_ready = 1'b1;
    rs = $urandom_range(3, 150);
    a_start = 1'b1;
    while (cyc < 1000 && n < 2) begin
      @(negedge clk);
      a_start = 1'b0;
      cyc++;
      if (cyc == rs) a_start = 1'b1;  // pulse while busy, must be ignored
      if (a_valid) begin
        checks++;
        if (a_px !== 2'(-2 + n) || a_py !== 1'b1 || a_delta !== ref_bundle(-2 + n, -1, 0, 0, 0)) begin
          failures++; $display("FAIL abort_pre_bundle n=%0d actual=(%0d,%0d) required=(%0d,-1)", n, a_px, a_py, -2 + n);
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL abort_pre_count actual=%0d required=2", n);
    end
    j = $urandom_range(2, 170);
    if ((j - 1) % 11 == 0) j++;
    repeat (j) @(negedge clk);
    checks++;
    if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
      failures++; $display("FAIL abort_computing actual=%b%b required=10", a_busy, a_valid);
    end
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_done !== 1'b0) begin
      failures++; $display("FAIL abort_idle actual=%b%b%b required=000", a_busy, a_valid, a_done);
    end
    repeat (200) begin
      @(negedge clk);
      if (a_done || a_valid || a_busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL abort_quiet actual=%0d active cycles required=0", bad);
    end
    // Restart from the first pixel, then abort together with a handshake.
    cyc = 0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    while (cyc < 400 && !a_valid) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (a_valid !== 1'b1 || a_px !== 2'b10 || a_py !== 1'b1 || a_delta !== ref_bundle(-2, -1, 0, 0, 0)) begin
      failures++; $display("FAIL restart_bundle actual=%b (%0d,%0d) required=1 (-2,-1)", a_valid, a_px, a_py);
    end
    a_ready = 1'b1;
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    bad = 0;
    repeat (20) begin
      if (a_done || a_valid || a_busy) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL abort_handshake actual=%0d active cycles required=0", bad);
    end
  endtask

  task automatic test_params();
    int nb = 0, nc = 0, nd = 0, cyc = 0, bdone = 0;
    int ex, ey;
    p_start = 1'b1;
    while (cyc < 1200 && (nb < 4 || nc < 4 || nd < 4 || cyc < 720)) begin
      @(negedge clk);
      p_start = 1'b0;
      cyc++;
      if (b_done) bdone++;
      if (b_valid) begin
        ex = -1 + nb % 2; ey = -1 + nb / 2;
        checks++;
        if (b_px !== 1'(ex) || b_py !== 1'(ey) || b_delta !== ref_bundle(ex, ey, 0, 2, 140)) begin
          failures++; $display("FAIL shift_offset n=%0d actual=(%0d,%0d) %h required=(%0d,%0d) %h", nb, b_px, b_py, b_delta, ex, ey, ref_bundle(ex, ey, 0, 2, 140));
        end
        if (nb == 3) begin
          checks++;
          if (b_delta[7:0] !== 8'd182 || b_delta[47:40] !== 8'd154) begin
            failures++; $display("FAIL shift_offset_centre actual=%0d,%0d required=182,154", b_delta[7:0], b_delta[47:40]);
          end
        end
        nb++;
      end
      if (c_valid) begin
        ex = -1 + nc % 2; ey = -1 + nc / 2;
        checks++;
        if (c_px !== 1'(ex) || c_py !== 1'(ey) || c_delta !== ref_bundle(ex, ey, 0, 2, 250)) begin
          failures++; $display("FAIL offset_clamp n=%0d actual=%h required=%h", nc, c_delta, ref_bundle(ex, ey, 0, 2, 250));
        end
        if (nc == 3) begin
          checks++;
          if (c_delta[7:0] !== 8'd255 || c_delta[47:40] !== 8'd255) begin
            failures++; $display("FAIL offset_clamp_centre actual=%0d,%0d required=255,255", c_delta[7:0], c_delta[47:40]);
          end
        end
        nc++;
      end
      if (d_valid) begin
        ex = -1 + nd % 2; ey = -1 + nd / 2;
        checks++;
        if (d_delta !== ref_bundle(ex, ey, 1048576, 0, 0) || d_delta !== {16{8'd255}}) begin
          failures++; $display("FAIL r2_saturate n=%0d actual=%h required=%h", nd, d_delta, {16{8'd255}});
        end
        nd++;
      end
    end
    checks++;
    if (nb != 4 || nc != 4 || nd != 4 || bdone != 1) begin
      failures++; $display("FAIL params_count actual=%0d,%0d,%0d done=%0d required=4,4,4 done=1", nb, nc, nd, bdone);
    end
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    a_ready = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    while (cyc < 400 && !a_valid) begin
      @(negedge clk);
      cyc++;
    end
    repeat ($urandom_range(1, 5)) @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || a_delta !== ref_bundle(-2, -1, 0, 0, 0)) begin
      failures++; $display("FAIL hold_before_reset actual=%b required=1", a_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_delta !== 128'd0) begin
      failures++; $display("FAIL async_reset actual=%b%b%b %h required=000 0", a_valid, a_busy, a_done, a_delta);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle actual=%b%b required=00", a_busy, a_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_abort();
    test_params();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
